mem_port_arbiter: RTL

//  Shares one Memory instance (write channel in_*, read channel out_*) between two requesters.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arb_rr_pick.sv | 31 +++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
// Consumed by mem_arb_rr_pick and mem_port_arbiter.
package mem_arb_pkg;

  localparam int NPORTS      = 2;
  localparam int PORT_CORE   = 0;
  localparam int PORT_LOADER = 1;

  typedef logic [0:0] port_t;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    DONE
  } state_t;

  function automatic logic [NPORTS-1:0] port_onehot(
    input port_t p
  );
    logic [NPORTS-1:0] oh;
    oh = '0;
    oh[p] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Winner selection between the core and loader ports.
// MEM_ARB_FIXED_PRIO_EN makes the core win every tie.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [NPORTS-1:0] valid,
  input  port_t             last_grant,
  output logic              any,
  output port_t             winner
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant[0];
`endif

  always_comb begin
    any    = |valid;
    winner = port_t'(PORT_CORE);
    unique case (1'b1)
      valid == 2'b10: winner = port_t'(PORT_LOADER);
`ifdef MEM_ARB_FIXED_PRIO_EN
      valid == 2'b11: winner = port_t'(PORT_CORE);
`else
      valid == 2'b11: winner = ~last_grant;
`endif
      default:        winner = port_t'(PORT_CORE);
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory between core (port 0) and loader (port 1).
// Round-robin unless MEM_ARB_FIXED_PRIO_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NPORTS-1:0]              rq_valid,
  input  logic [NPORTS-1:0]              rq_we,
  input  logic [NPORTS-1:0][ADDR_W-1:0]  rq_addr,
  input  logic [NPORTS-1:0][DATA_W-1:0]  rq_wdata,
  output logic [NPORTS-1:0]              rq_done,
  output logic [DATA_W-1:0]              rq_rdata,
  output logic [ADDR_W-1:0]              mem_in_addr,
  output logic [DATA_W-1:0]              mem_in_data,
  output logic                           mem_in_valid,
  input  logic                           mem_in_ready,
  output logic [ADDR_W-1:0]              mem_out_addr,
  output logic                           mem_out_valid,
  input  logic [DATA_W-1:0]              mem_out_data,
  input  logic                           mem_out_ready
);

  state_t state;
  state_t state_d;

  port_t last_grant;
  port_t grant;
  port_t last_grant_d;
  port_t grant_d;

  logic  pick_any;
  port_t pick_winner;

  logic [NPORTS-1:0] done_d;
  logic [DATA_W-1:0] rdata_d;
  logic [ADDR_W-1:0] in_addr_d;
  logic [DATA_W-1:0] in_data_d;
  logic [ADDR_W-1:0] out_addr_d;
  logic              in_valid_d;
  logic              out_valid_d;

  logic take;

  mem_arb_rr_pick u_pick (
    .valid      (rq_valid),
    .last_grant (last_grant),
    .any        (pick_any),
    .winner     (pick_winner)
  );

  assign take = (state == IDLE) && pick_any;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_d = rq_we[pick_winner] ? WR : RD;
        end
      end
      WR:   if (mem_in_ready)  state_d = DONE;
      RD:   if (mem_out_ready) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for every registered output; the memory sees the
  // latched copy of the winner's request, never the live inputs.
  always_comb begin
    grant_d      = grant;
    last_grant_d = last_grant;
    in_addr_d    = mem_in_addr;
    in_data_d    = mem_in_data;
    out_addr_d   = mem_out_addr;
    rdata_d      = rq_rdata;
    in_valid_d   = (state_d == WR);
    out_valid_d  = (state_d == RD);
    done_d       = '0;
    if (take) begin
      grant_d      = pick_winner;
      last_grant_d = pick_winner;
      if (rq_we[pick_winner]) begin
        in_addr_d = rq_addr[pick_winner];
        in_data_d = rq_wdata[pick_winner];
      end else begin
        out_addr_d = rq_addr[pick_winner];
      end
    end
    if ((state == RD) && mem_out_ready) begin
      rdata_d = mem_out_data;
    end
    if (state_d == DONE) begin
      done_d = port_onehot(grant);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant         <= port_t'(PORT_CORE);
      last_grant    <= port_t'(PORT_LOADER);
      mem_in_addr   <= '0;
      mem_in_data   <= '0;
      mem_in_valid  <= 1'b0;
      mem_out_addr  <= '0;
      mem_out_valid <= 1'b0;
      rq_done       <= '0;
      rq_rdata      <= '0;
    end else begin
      grant         <= grant_d;
      last_grant    <= last_grant_d;
      mem_in_addr   <= in_addr_d;
      mem_in_data   <= in_data_d;
      mem_in_valid  <= in_valid_d;
      mem_out_addr  <= out_addr_d;
      mem_out_valid <= out_valid_d;
      rq_done       <= done_d;
      rq_rdata      <= rdata_d;
    end
  end

endmodule
